calc1_top: RTL and testbench
============================

Name: calc1_top

Overview:
- Four-port 32-bit integer calculator. Each port issues a two-cycle request (command + operand1, then operand2) and receives a one-cycle response code with result data.
- Ports are fully independent: each has its own request FSM and its own ALU/shifter path, and all four may be active concurrently.
- Top-level compute block; requesters drive the reqN inputs directly and sample out_respN/out_dataN.

Parameters:
- none (data width fixed at 32, command width 4, response width 2)

Ports:
- c_clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- reqN_cmd_in (N=1..4)  input  4  command for port N; nonzero value starts a request
- reqN_data_in (N=1..4)  input  32  operand1 in the command cycle, operand2 in the following cycle
- out_respN (N=1..4)  output  2  response: 0 none, 1 success, 2 overflow/underflow, 3 invalid command
- out_dataN (N=1..4)  output  32  result; valid only when out_respN=1, otherwise 0

Behaviour:
- Reset (reset=0, async): all out_respN=0, out_dataN=0, every port FSM forced to IDLE, captured operands cleared. Reset mid-request aborts the request with no response. Normal operation resumes on the first rising edge after reset=1.
- Per-port FSM, states IDLE and OP2:
  - IDLE: at edge k, if reqN_cmd_in != 0, capture cmd and op1 = reqN_data_in, go to OP2. If cmd = 0, stay in IDLE with no effect.
  - OP2: at edge k+1, capture op2 = reqN_data_in (reqN_cmd_in ignored), compute the result, load the output registers, return to IDLE.
- Timing: out_respN/out_dataN are valid from edge k+1 to edge k+2, exactly one cycle, then cleared to 0 at k+2 unless a new result loads.
- Fixed latency: one cycle after the operand2 cycle; minimum request issue interval is 2 cycles. A new cmd presented at edge k+2 is accepted.
- Commands:
  - 1 add: sum = op1 + op2 as 33-bit. Carry out gives resp 2, data 0; else resp 1, data = sum[31:0].
  - 2 sub: op1 − op2. op1 < op2 (unsigned) gives resp 2, data 0; else resp 1, data = op1 − op2. Equal operands give resp 1, data 0.
  - 5 shl: resp 1, data = op1 << op2[4:0] (logical, zero fill); op2[31:5] ignored.
  - 6 shr: resp 1, data = op1 >> op2[4:0] (logical); op2[31:5] ignored.
  - 3, 4, 7–15: still consume the operand2 cycle; resp 3, data 0.
- Operands are unsigned. No state carries between requests: each result depends only on that request's cmd/op1/op2, so there is no dirty-state leakage.
- Ports share nothing. Simultaneous requests on all four ports each complete with the same fixed latency.

Test Plan:
- Response codes, each port: cmd 0 [0x64,0x27] -> resp 0 for 10 cycles. cmd 1 [0x64,0x27] -> resp 1, data 0x8B. cmd 1 [0xFFFFFFFF,0x1] -> resp 2, data 0. cmd 2 [0x22,0x23] -> resp 2.
- Operations, each port: add [5,1] -> 6. sub [5,2] -> 3. shl [3,2] -> 0xC. shr [0xC,2] -> 3. Each has resp 1 exactly one cycle after the operand2 cycle, and resp 0 on the following cycle.
- Invalid command: cmd 4 [1,1] -> resp 3, data 0. Port returns to IDLE, and the next add [2,3] -> resp 1, data 5.
- Boundaries: add [0xFFFFFFFE,1] -> resp 1, data 0xFFFFFFFF. sub [7,7] -> resp 1, data 0. shl [1,31] -> 0x80000000. shl [1,32] -> data 1 (amount 0).
- Concurrency and clean state: 80 random add/sub/shl/shr requests spread over a shuffled port order, including simultaneous issues on all four ports -> every response matches the reference model.
- Reset: assert reset=0 during an OP2 cycle -> outputs go to 0 immediately and no response follows. After release, add [5,1] -> 6.

Source files
------------

// File: rtl/calc1_top.sv
// Four-port 32-bit integer calculator.
// Each port runs an independent two-cycle request FSM with its own ALU.

module calc1_port (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [3:0]  cmd_in,
    input  logic [31:0] data_in,
    output logic [1:0]  resp,
    output logic [31:0] data
);

    typedef enum logic {
        IDLE = 1'b0,
        OP2  = 1'b1
    } state_t;

    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_OVF  = 2'd2;
    localparam logic [1:0] RESP_INV  = 2'd3;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cmd_q;
    logic [31:0] op1_q;
    logic [32:0] sum;
    logic [1:0]  resp_nxt;
    logic [31:0] data_nxt;

    // State register
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a nonzero command opens a request, OP2 always closes it
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_in != 4'd0) state_nxt = OP2;
            OP2:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command and operand1 capture in the command cycle
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            cmd_q <= 4'd0;
            op1_q <= 32'd0;
        end else if (state == IDLE && cmd_in != 4'd0) begin
            cmd_q <= cmd_in;
            op1_q <= data_in;
        end
    end

    // Result: operand2 is consumed straight from the input in OP2
    always_comb begin
        resp_nxt = RESP_NONE;
        data_nxt = 32'd0;
        sum      = {1'b0, op1_q} + {1'b0, data_in};
        if (state == OP2) begin
            case (cmd_q)
                CMD_ADD: begin
                    if (sum[32]) begin
                        resp_nxt = RESP_OVF;
                    end else begin
                        resp_nxt = RESP_OK;
                        data_nxt = sum[31:0];
                    end
                end
                CMD_SUB: begin
                    if (op1_q < data_in) begin
                        resp_nxt = RESP_OVF;
                    end else begin
                        resp_nxt = RESP_OK;
                        data_nxt = op1_q - data_in;
                    end
                end
                CMD_SHL: begin
                    resp_nxt = RESP_OK;
                    data_nxt = op1_q << data_in[4:0];
                end
                CMD_SHR: begin
                    resp_nxt = RESP_OK;
                    data_nxt = op1_q >> data_in[4:0];
                end
                default: resp_nxt = RESP_INV;
            endcase
        end
    end

    // Output register: a result shows for exactly one cycle
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            resp <= RESP_NONE;
            data <= 32'd0;
        end else begin
            resp <= resp_nxt;
            data <= data_nxt;
        end
    end

endmodule

module calc1_top (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [3:0]  req1_cmd_in,
    input  logic [31:0] req1_data_in,
    input  logic [3:0]  req2_cmd_in,
    input  logic [31:0] req2_data_in,
    input  logic [3:0]  req3_cmd_in,
    input  logic [31:0] req3_data_in,
    input  logic [3:0]  req4_cmd_in,
    input  logic [31:0] req4_data_in,
    output logic [1:0]  out_resp1,
    output logic [31:0] out_data1,
    output logic [1:0]  out_resp2,
    output logic [31:0] out_data2,
    output logic [1:0]  out_resp3,
    output logic [31:0] out_data3,
    output logic [1:0]  out_resp4,
    output logic [31:0] out_data4
);

    calc1_port u_port1 (
        .c_clk   (c_clk),
        .reset   (reset),
        .cmd_in  (req1_cmd_in),
        .data_in (req1_data_in),
        .resp    (out_resp1),
        .data    (out_data1)
    );

    calc1_port u_port2 (
        .c_clk   (c_clk),
        .reset   (reset),
        .cmd_in  (req2_cmd_in),
        .data_in (req2_data_in),
        .resp    (out_resp2),
        .data    (out_data2)
    );

    calc1_port u_port3 (
        .c_clk   (c_clk),
        .reset   (reset),
        .cmd_in  (req3_cmd_in),
        .data_in (req3_data_in),
        .resp    (out_resp3),
        .data    (out_data3)
    );

    calc1_port u_port4 (
        .c_clk   (c_clk),
        .reset   (reset),
        .cmd_in  (req4_cmd_in),
        .data_in (req4_data_in),
        .resp    (out_resp4),
        .data    (out_data4)
    );

endmodule

// File: tb/tb_calc1_top.sv
// Self-checking bench for calc1_top.
// Random and directed requests against a transaction-level reference.

module tb_calc1_top;

    logic        c_clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  cmd_v [4];
    logic [31:0] dat_v [4];
    logic [1:0]  resp_o [4];
    logic [31:0] data_o [4];

    logic [3:0]  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in;
    logic [31:0] req1_data_in, req2_data_in, req3_data_in, req4_data_in;
    logic [1:0]  out_resp1, out_resp2, out_resp3, out_resp4;
    logic [31:0] out_data1, out_data2, out_data3, out_data4;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: one outstanding request per port at most
    bit          pend  [4];
    logic [3:0]  pcmd  [4];
    logic [31:0] pop1  [4];
    logic [1:0]  eresp [4];
    logic [31:0] edata [4];

    always #5 c_clk = ~c_clk;

    assign req1_cmd_in  = cmd_v[0];
    assign req2_cmd_in  = cmd_v[1];
    assign req3_cmd_in  = cmd_v[2];
    assign req4_cmd_in  = cmd_v[3];
    assign req1_data_in = dat_v[0];
    assign req2_data_in = dat_v[1];
    assign req3_data_in = dat_v[2];
    assign req4_data_in = dat_v[3];
    assign resp_o[0] = out_resp1;
    assign resp_o[1] = out_resp2;
    assign resp_o[2] = out_resp3;
    assign resp_o[3] = out_resp4;
    assign data_o[0] = out_data1;
    assign data_o[1] = out_data2;
    assign data_o[2] = out_data3;
    assign data_o[3] = out_data4;

    calc1_top dut (
        .c_clk        (c_clk),
        .reset        (reset),
        .req1_cmd_in  (req1_cmd_in),
        .req1_data_in (req1_data_in),
        .req2_cmd_in  (req2_cmd_in),
        .req2_data_in (req2_data_in),
        .req3_cmd_in  (req3_cmd_in),
        .req3_data_in (req3_data_in),
        .req4_cmd_in  (req4_cmd_in),
        .req4_data_in (req4_data_in),
        .out_resp1    (out_resp1),
        .out_data1    (out_data1),
        .out_resp2    (out_resp2),
        .out_data2    (out_data2),
        .out_resp3    (out_resp3),
        .out_data3    (out_data3),
        .out_resp4    (out_resp4),
        .out_data4    (out_data4)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // Calculator rules in plain wide arithmetic: {resp, data}
    function automatic logic [33:0] ref_calc(input logic [3:0] c,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        longint unsigned s;
        int unsigned     amt;
        amt = b % 32;
        case (c)
            4'd1: begin
                s = longint'(a) + longint'(b);
                if (s > 64'hFFFF_FFFF) return {2'd2, 32'd0};
                return {2'd1, s[31:0]};
            end
            4'd2: begin
                if (a < b) return {2'd2, 32'd0};
                return {2'd1, a - b};
            end
            4'd5: return {2'd1, a << amt};
            4'd6: return {2'd1, a >> amt};
            default: return {2'd3, 32'd0};
        endcase
    endfunction

    // One clock: predict, advance, compare every port, then idle inputs
    task automatic step();
        for (int p = 0; p < 4; p++) begin
            eresp[p] = 2'd0;
            edata[p] = 32'd0;
            if (!reset) begin
                pend[p] = 1'b0;
            end else if (pend[p]) begin
                {eresp[p], edata[p]} = ref_calc(pcmd[p], pop1[p], dat_v[p]);
                pend[p] = 1'b0;
            end else if (cmd_v[p] != 4'd0) begin
                pend[p] = 1'b1;
                pcmd[p] = cmd_v[p];
                pop1[p] = dat_v[p];
            end
        end
        @(posedge c_clk);
        @(negedge c_clk);
        for (int p = 0; p < 4; p++) begin
            check($sformatf("p%0d resp", p + 1), 32'(resp_o[p]), 32'(eresp[p]));
            check($sformatf("p%0d data", p + 1), data_o[p], edata[p]);
            cmd_v[p] = 4'd0;
            dat_v[p] = 32'd0;
        end
    endtask

    // Directed request on one port with constant expectations
    task automatic dreq(input int p, input logic [3:0] c,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] er, input logic [31:0] ed);
        cmd_v[p] = c;
        dat_v[p] = a;
        step();
        cmd_v[p] = 4'($urandom_range(0, 15));
        dat_v[p] = b;
        step();
        check($sformatf("p%0d dir resp", p + 1), 32'(resp_o[p]), 32'(er));
        check($sformatf("p%0d dir data", p + 1), data_o[p], ed);
        step();
        check($sformatf("p%0d clr resp", p + 1), 32'(resp_o[p]), 32'd0);
    endtask

    initial begin
        int issued;
        int cyc;
        int perm [4];
        logic [3:0] ops [4];
        ops[0] = 4'd1; ops[1] = 4'd2; ops[2] = 4'd5; ops[3] = 4'd6;
        for (int p = 0; p < 4; p++) begin
            cmd_v[p] = 4'd0;
            dat_v[p] = 32'd0;
            pend[p]  = 1'b0;
            pcmd[p]  = 4'd0;
            pop1[p]  = 32'd0;
        end

        #1;
        for (int p = 0; p < 4; p++) begin
            check("rst resp", 32'(resp_o[p]), 32'd0);
            check("rst data", data_o[p], 32'd0);
        end
        @(negedge c_clk);
        @(negedge c_clk);
        reset = 1'b1;

        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 10; i++) begin
                dat_v[p] = (i % 2 == 0) ? 32'h64 : 32'h27;
                step();
            end
            dreq(p, 4'd1, 32'h64, 32'h27, 2'd1, 32'h8B);
            dreq(p, 4'd1, 32'hFFFF_FFFF, 32'h1, 2'd2, 32'd0);
            dreq(p, 4'd2, 32'h22, 32'h23, 2'd2, 32'd0);
            dreq(p, 4'd1, 32'd5, 32'd1, 2'd1, 32'd6);
            dreq(p, 4'd2, 32'd5, 32'd2, 2'd1, 32'd3);
            dreq(p, 4'd5, 32'd3, 32'd2, 2'd1, 32'hC);
            dreq(p, 4'd6, 32'hC, 32'd2, 2'd1, 32'd3);
            dreq(p, 4'd4, 32'd1, 32'd1, 2'd3, 32'd0);
            dreq(p, 4'd1, 32'd2, 32'd3, 2'd1, 32'd5);
            dreq(p, 4'd1, 32'hFFFF_FFFE, 32'd1, 2'd1, 32'hFFFF_FFFF);
            dreq(p, 4'd2, 32'd7, 32'd7, 2'd1, 32'd0);
            dreq(p, 4'd5, 32'd1, 32'd31, 2'd1, 32'h8000_0000);
            dreq(p, 4'd5, 32'd1, 32'd32, 2'd1, 32'd1);
        end

        // Back-to-back issue: new command accepted right after OP2
        cmd_v[2] = 4'd1; dat_v[2] = 32'd10; step();
        dat_v[2] = 32'd20; step();
        cmd_v[2] = 4'd2; dat_v[2] = 32'd9; step();
        dat_v[2] = 32'd4; step();
        check("b2b resp", 32'(resp_o[2]), 32'd1);
        check("b2b data", data_o[2], 32'd5);
        step();

        issued = 0;
        cyc = 0;
        while ((issued < 80 || pend[0] || pend[1] || pend[2] || pend[3])
               && cyc < 2000) begin
            bit all_go;
            all_go = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 4; i++) perm[i] = i;
            for (int i = 3; i > 0; i--) begin
                int j;
                int t;
                j = $urandom_range(0, i);
                t = perm[i];
                perm[i] = perm[j];
                perm[j] = t;
            end
            for (int i = 0; i < 4; i++) begin
                int p;
                p = perm[i];
                if (pend[p]) begin
                    cmd_v[p] = 4'($urandom_range(0, 15));
                    dat_v[p] = $urandom_range(0, 1) ? $urandom
                                                    : $urandom_range(0, 40);
                end else if (issued < 80 &&
                             (all_go || $urandom_range(0, 2) == 0)) begin
                    cmd_v[p] = ops[$urandom_range(0, 3)];
                    dat_v[p] = $urandom_range(0, 1) ? $urandom
                                                    : 32'hFFFF_FFF0 + $urandom_range(0, 15);
                    issued++;
                end else begin
                    dat_v[p] = $urandom;
                end
            end
            step();
            cyc++;
        end
        check("rand drained", 32'(issued), 32'd80);
        step();

        // Reset while port1 shows a result and port2 sits in OP2
        cmd_v[0] = 4'd1; dat_v[0] = 32'd5; step();
        dat_v[0] = 32'd1; cmd_v[1] = 4'd2; dat_v[1] = 32'd9; step();
        check("pre-rst resp", 32'(resp_o[0]), 32'd1);
        dat_v[1] = 32'd3;
        reset = 1'b0;
        #1;
        check("async rst resp1", 32'(resp_o[0]), 32'd0);
        check("async rst data1", data_o[0], 32'd0);
        check("async rst resp2", 32'(resp_o[1]), 32'd0);
        dat_v[1] = 32'd3;
        step();
        reset = 1'b1;
        dat_v[1] = 32'd3;
        step();
        check("no late resp2", 32'(resp_o[1]), 32'd0);
        step();
        dreq(0, 4'd1, 32'd5, 32'd1, 2'd1, 32'd6);
        dreq(1, 4'd1, 32'd5, 32'd1, 2'd1, 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
